// File: rtl/password_checker_if.sv
// Bundles the password-store write port, the keypad entry strobe and the lock
// status outputs of password_checker.
interface password_checker_if #(
  parameter int FAIL_W = 2
);
  logic              wr_en;
  logic [1:0]        wr_addr;
  logic [3:0]        wr_data;
  logic              digit_valid;
  logic [3:0]        digit;
  logic              clear;
  logic              unlocked;
  logic              fail;
  logic              alarm;
  logic [FAIL_W-1:0] fail_count;
  logic [2:0]        dbg_state;

  modport master (
    output wr_en, wr_addr, wr_data, digit_valid, digit, clear,
    input  unlocked, fail, alarm, fail_count, dbg_state
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, digit_valid, digit, clear,
    output unlocked, fail, alarm, fail_count, dbg_state
  );
endinterface

// File: rtl/password_checker.sv
// Serial 4-digit code checker with a writable password store, failure counter and
// latched alarm. Optional admin override from alarm: define ADMIN_OVERRIDE_EN.
module password_checker #(
  parameter int          MAX_FAIL   = 3,
  parameter int          FAIL_W     = 2,
  parameter logic [15:0] ADMIN_CODE = 16'h4321
) (
  input  logic CLK,
  input  logic RST,
  password_checker_if.slave bus
);

  typedef enum logic [2:0] {
    S_D0    = 3'd0,
    S_D1    = 3'd1,
    S_D2    = 3'd2,
    S_D3    = 3'd3,
    S_OPEN  = 3'd4,
    S_ALARM = 3'd5
  } state_e;

  localparam logic [FAIL_W-1:0] MAX_FC  = FAIL_W'(MAX_FAIL);
  localparam logic [FAIL_W:0]   MAX_CMP = (FAIL_W+1)'(MAX_FAIL);

  generate
    if (MAX_FAIL < 1 || MAX_FAIL > (2**FAIL_W - 1)) begin : g_bad_max_fail
      $error("password_checker: MAX_FAIL out of range for FAIL_W");
    end
  endgenerate

  state_e            state, state_nx;
  logic [3:0][3:0]   store;
  logic              mismatch, mismatch_nx, mm_digit;
  logic [FAIL_W-1:0] fail_count, fc_nx;
  logic [FAIL_W:0]   fc_inc;
  logic              fail_q, fail_nx;
  logic              unlocked_q, alarm_q;

`ifdef ADMIN_OVERRIDE_EN
  logic        adm_mm, adm_mm_nx, adm_mm_digit;
  logic [1:0]  adm_idx, adm_idx_nx, adm_k;
  logic [15:0] admin_code;
  assign admin_code   = ADMIN_CODE;
  // In alarm the admin sequence runs on its own index; otherwise it follows S_Dk
  assign adm_k        = (state == S_ALARM) ? adm_idx : state[1:0];
  assign adm_mm_digit = adm_mm | (bus.digit != admin_code[{adm_k, 2'b00} +: 4]);
`else
  logic unused_admin;
  assign unused_admin = ^ADMIN_CODE;
`endif

  // Compare uses the pre-write store value, so a same-cycle write is not seen
  assign mm_digit = mismatch | (bus.digit != store[state[1:0]]);
  assign fc_inc   = {1'b0, fail_count} + {{FAIL_W{1'b0}}, 1'b1};

  always_comb begin
    state_nx    = state;
    mismatch_nx = mismatch;
    fc_nx       = fail_count;
    fail_nx     = 1'b0;
`ifdef ADMIN_OVERRIDE_EN
    adm_mm_nx   = adm_mm;
    adm_idx_nx  = adm_idx;
`endif
    case (state)
      S_D0, S_D1, S_D2, S_D3: begin
        if (bus.clear) begin
          state_nx    = S_D0;
          mismatch_nx = 1'b0;
`ifdef ADMIN_OVERRIDE_EN
          adm_mm_nx   = 1'b0;
`endif
        end else if (bus.digit_valid) begin
          if (state != S_D3) begin
            state_nx    = state_e'(state + 3'd1);
            mismatch_nx = mm_digit;
`ifdef ADMIN_OVERRIDE_EN
            adm_mm_nx   = adm_mm_digit;
`endif
          end else begin
            mismatch_nx = 1'b0;
`ifdef ADMIN_OVERRIDE_EN
            adm_mm_nx   = 1'b0;
            adm_idx_nx  = 2'd0;
            if (!adm_mm_digit) begin
              state_nx = S_OPEN;
              fc_nx    = '0;
            end else
`endif
            if (!mm_digit) begin
              state_nx = S_OPEN;
              fc_nx    = '0;
            end else if (fc_inc == MAX_CMP) begin
              // The tripping failure raises alarm only, never a fail pulse
              state_nx = S_ALARM;
              fc_nx    = MAX_FC;
            end else begin
              state_nx = S_D0;
              fc_nx    = fc_inc[FAIL_W-1:0];
              fail_nx  = 1'b1;
            end
          end
        end
      end
      S_OPEN: begin
        if (bus.clear) state_nx = S_D0;
      end
      S_ALARM: begin
`ifdef ADMIN_OVERRIDE_EN
        if (bus.clear) begin
          adm_idx_nx = 2'd0;
          adm_mm_nx  = 1'b0;
        end else if (bus.digit_valid) begin
          if (adm_idx == 2'd3) begin
            adm_idx_nx = 2'd0;
            adm_mm_nx  = 1'b0;
            if (!adm_mm_digit) begin
              state_nx = S_OPEN;
              fc_nx    = '0;
            end
          end else begin
            adm_idx_nx = adm_idx + 2'd1;
            adm_mm_nx  = adm_mm_digit;
          end
        end
`endif
      end
      default: state_nx = S_D0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_D0;
      store      <= '0;
      mismatch   <= 1'b0;
      fail_count <= '0;
      fail_q     <= 1'b0;
      unlocked_q <= 1'b0;
      alarm_q    <= 1'b0;
`ifdef ADMIN_OVERRIDE_EN
      adm_mm     <= 1'b0;
      adm_idx    <= 2'd0;
`endif
    end else begin
      state      <= state_nx;
      mismatch   <= mismatch_nx;
      fail_count <= fc_nx;
      fail_q     <= fail_nx;
      unlocked_q <= (state_nx == S_OPEN);
      alarm_q    <= (state_nx == S_ALARM);
      if (bus.wr_en) store[bus.wr_addr] <= bus.wr_data;
`ifdef ADMIN_OVERRIDE_EN
      adm_mm     <= adm_mm_nx;
      adm_idx    <= adm_idx_nx;
`endif
    end
  end

  assign bus.unlocked   = unlocked_q;
  assign bus.fail       = fail_q;
  assign bus.alarm      = alarm_q;
  assign bus.fail_count = fail_count;
  assign bus.dbg_state  = state;

endmodule

// File: tb/tb_password_checker.sv
// Directed bench for password_checker: store writes, unlock/re-lock, abort,
// write collision, alarm latch, reset, and the admin override when enabled.
module tb_password_checker;
  localparam int FAIL_W = 2;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   errors = 0;
  int   checks = 0;

  password_checker_if #(.FAIL_W(FAIL_W)) bus ();

  password_checker #(
    .MAX_FAIL  (3),
    .FAIL_W    (FAIL_W),
    .ADMIN_CODE(16'h4321)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic wr(input logic [1:0] a, input logic [3:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic strobe(input logic [3:0] d);
    bus.digit_valid = 1'b1; bus.digit = d;
    tick();
    bus.digit_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  // code is written in entry order, first digit in the top nibble
  task automatic enter(input logic [15:0] code, input int gap);
    for (int k = 0; k < 4; k++) begin
      strobe(code[4*(3-k) +: 4]);
      if (k != 3) idle(gap);
    end
  endtask

  task automatic chk_out(input string tag, input logic u, input logic f, input logic a,
                         input logic [1:0] fc, input logic [2:0] st);
    chk({tag, ".unlocked"},   16'(bus.unlocked),   16'(u));
    chk({tag, ".fail"},       16'(bus.fail),       16'(f));
    chk({tag, ".alarm"},      16'(bus.alarm),      16'(a));
    chk({tag, ".fail_count"}, 16'(bus.fail_count), 16'(fc));
    chk({tag, ".state"},      16'(bus.dbg_state),  16'(st));
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.digit_valid = 1'b0; bus.digit = '0; bus.clear = 1'b0;
    idle(2);
    chk_out("reset", 0, 0, 0, 2'd0, 3'd0);
    RST = 1'b0;

    // store 7,3,0,9 and unlock with idle gaps
    wr(2'd0, 4'd7); wr(2'd1, 4'd3); wr(2'd2, 4'd0); wr(2'd3, 4'd9);
    strobe(4'd7); idle(2); strobe(4'd3); idle(2); strobe(4'd0); idle(2);
    chk_out("pre4th", 0, 0, 0, 2'd0, 3'd3);
    strobe(4'd9);
    chk_out("unlock", 1, 0, 0, 2'd0, 3'd4);
    strobe(4'd1);
    chk_out("open_ignores_digit", 1, 0, 0, 2'd0, 3'd4);

    // re-lock, then one wrong entry
    pulse_clear();
    chk_out("relock", 0, 0, 0, 2'd0, 3'd0);
    enter(16'h7308, 0);
    chk_out("wrong1", 0, 1, 0, 2'd1, 3'd0);
    idle(1);
    chk_out("fail_width", 0, 0, 0, 2'd1, 3'd0);

    // abort: clear beats a coincident digit
    strobe(4'd7); strobe(4'd3);
    chk_out("mid_entry", 0, 0, 0, 2'd1, 3'd2);
    bus.clear = 1'b1; bus.digit_valid = 1'b1; bus.digit = 4'd0;
    tick();
    bus.clear = 1'b0; bus.digit_valid = 1'b0;
    chk_out("abort", 0, 0, 0, 2'd1, 3'd0);
    enter(16'h7309, 1);
    chk_out("after_abort", 1, 0, 0, 2'd0, 3'd4);
    pulse_clear();

    // write collision: digit compares against the old store value
    strobe(4'd7);
    bus.digit_valid = 1'b1; bus.digit = 4'd3;
    bus.wr_en = 1'b1; bus.wr_addr = 2'd1; bus.wr_data = 4'd5;
    tick();
    bus.digit_valid = 1'b0; bus.wr_en = 1'b0;
    chk_out("collide", 0, 0, 0, 2'd0, 3'd2);
    strobe(4'd0); strobe(4'd9);
    chk_out("collide_open", 1, 0, 0, 2'd0, 3'd4);
    pulse_clear();
    enter(16'h7509, 0);
    chk_out("new_pw", 1, 0, 0, 2'd0, 3'd4);
    pulse_clear();

    // three failures, last one trips the alarm without a fail pulse
    enter(16'hF509, 0);
    chk_out("alarm_f1", 0, 1, 0, 2'd1, 3'd0);
    enter(16'h7508, 0);
    chk_out("alarm_f2", 0, 1, 0, 2'd2, 3'd0);
    enter(16'h0000, 0);
    chk_out("alarm_f3", 0, 0, 1, 2'd3, 3'd5);
    enter(16'h7509, 0);
    chk_out("alarm_digits", 0, 0, 1, 2'd3, 3'd5);
    pulse_clear();
    chk_out("alarm_clear", 0, 0, 1, 2'd3, 3'd5);

    // reset exits alarm and zeroes the store
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk_out("rst_alarm", 0, 0, 0, 2'd0, 3'd0);
    enter(16'h0000, 0);
    chk_out("zero_store", 1, 0, 0, 2'd0, 3'd4);
    pulse_clear();

    // admin sequence from alarm
    enter(16'h1111, 0); enter(16'h1111, 0); enter(16'h1111, 0);
    chk_out("alarm2", 0, 0, 1, 2'd3, 3'd5);
    enter(16'h1235, 0);
    chk_out("admin_wrong", 0, 0, 1, 2'd3, 3'd5);
    enter(16'h1234, 0);
`ifdef ADMIN_OVERRIDE_EN
    chk_out("admin_ok", 1, 0, 0, 2'd0, 3'd4);
`else
    chk_out("no_admin", 0, 0, 1, 2'd3, 3'd5);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/password_checker.md
Name: password_checker

Overview:
- Downstream consumer of the password setter's write stream.
- Holds the 4-digit password in a 4x4-bit store written via wr_en/wr_addr/wr_data.
- Verifies a serially entered 4-digit code against the store; drives unlocked/fail/alarm for the lock top level.
- Counts consecutive failures and latches an alarm at a configurable limit.

Parameters:
- MAX_FAIL, 3, consecutive failed entries that trigger alarm; legal range 1..(2**FAIL_W - 1).
- FAIL_W, 2, width of fail_count.
- ADMIN_CODE, 16'h4321, admin sequence, digit k in bits [4k+3:4k], so entry order is 1,2,3,4. Used only with ADMIN_OVERRIDE_EN.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous active-high reset.
- wr_en  in  1  store write strobe (setter's shouldWrite).
- wr_addr  in  2  store index (setter's address).
- wr_data  in  4  digit to store (setter's data).
- digit_valid  in  1  one-cycle strobe: an entered digit is present.
- digit  in  4  entered digit; raw 4-bit compare, values 10..15 are not filtered.
- clear  in  1  abort entry / re-lock.
- unlocked  out  1  high while in S_OPEN.
- fail  out  1  one-cycle pulse after a wrong 4-digit entry.
- alarm  out  1  high while in S_ALARM.
- fail_count  out  FAIL_W  consecutive failures.
- dbg_state  out  3  current state encoding, for debug.

Behaviour:
- Reset: synchronous, active-high.
  - Store entries = 0, state = S_D0, mismatch = 0, fail_count = 0.
  - unlocked = 0, fail = 0, alarm = 0.
  - RST overrides every other input, including mid-entry, S_OPEN and S_ALARM.
- Store writes:
  - If wr_en is high, store[wr_addr] <= wr_data at the clock edge.
  - Writes are accepted in every state.
  - A digit compared in the same cycle as a write to the same index compares against the old value.
- States (3-bit enum): S_D0, S_D1, S_D2, S_D3, S_OPEN, S_ALARM.
- S_Dk with digit_valid=1:
  - mismatch_next = mismatch | (digit != store[k]).
  - S_D0..S_D2 advance to the next S_D state.
  - S_D3 resolves the entry:
    - mismatch_next == 0: go to S_OPEN, fail_count <= 0.
    - mismatch_next == 1 and fail_count+1 == MAX_FAIL: go to S_ALARM, fail_count <= MAX_FAIL.
    - Otherwise: go to S_D0, fail_count += 1, fail <= 1 for one cycle.
    - mismatch is cleared on every resolution.
- Latency: the 4th digit_valid in cycle n produces unlocked, fail or alarm asserted in cycle n+1. All outputs are registered.
- Missing strobe: in S_Dk with digit_valid=0, hold state.
- Gaps: any number of idle cycles between digits is allowed.
- S_OPEN:
  - digit_valid is ignored.
  - clear moves to S_D0, so unlocked drops in the next cycle.
- S_ALARM:
  - digit_valid and clear are ignored; only RST exits.
  - fail_count holds at MAX_FAIL.
- clear in S_D0..S_D3: go to S_D0, mismatch <= 0, fail_count unchanged.
- clear together with digit_valid in the same cycle: clear wins and the digit is dropped.
- fail_count saturates at MAX_FAIL and never wraps.
- fail must never be asserted in the same cycle as alarm. The failure that trips the alarm raises alarm only, with no fail pulse.

Optional Feature:
ADMIN_OVERRIDE_EN
- Defined:
  - A parallel admin_mismatch flag tracks entry against ADMIN_CODE, same rules as mismatch.
  - S_ALARM additionally accepts digit entry, with its own 2-bit index.
  - Resolution, in S_D3 or after the 4th digit in S_ALARM, when admin_mismatch_next == 0: go to S_OPEN, fail_count <= 0, alarm cleared. This applies regardless of the stored password.
  - A wrong admin entry in S_ALARM stays in S_ALARM with no fail pulse.
  - clear in S_ALARM resets the admin index.
- Undefined: admin logic is absent, and behaviour is exactly as above.

Test Plan:
- Store write/read: RST; write 7,3,0,9 to addr 0..3; enter 7,3,0,9 with 2 idle cycles between digits -> unlocked=1 exactly one cycle after the 4th strobe; fail_count=0; dbg_state=S_OPEN.
- Unlock then re-lock: from the unlocked state, pulse clear -> unlocked=0 next cycle; enter 7,3,0,8 -> fail pulse width 1, fail_count=1, state S_D0.
- Alarm entry: MAX_FAIL=3; three wrong entries -> fail pulses at failures 1 and 2; 3rd failure -> alarm=1, fail=0, fail_count=3; further digits and clear have no effect; RST -> alarm=0, store all 0.
- Abort: enter 7,3 then clear coincident with digit_valid(0) -> state S_D0, fail_count unchanged; enter 7,3,0,9 -> unlock.
- Write collision: in S_D1 with store[1]=3, assert digit_valid digit=3 together with wr_en, addr 1, data 5 -> digit accepted as match; next entry 7,5,0,9 unlocks.
- ADMIN_OVERRIDE_EN: drive into alarm, enter 1,2,3,4 -> unlocked=1, alarm=0, fail_count=0; entering 1,2,3,5 in alarm -> stays alarm.
